// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: execution sequencer producing the CPU's one-cycle Go enable (free run, turbo, halt, single-step).
// Define CPU_BREAKPOINT_EN to include the instruction-pointer breakpoint; otherwise BRK is unreachable.
module cpu_step_ctrl #(
  parameter int TICK_MAX  = 12500000,
  parameter int CNT_W     = 28,
  parameter int DB_CYCLES = 250000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Turbo,
  input  logic [2:0] Btns,
  input  logic [7:0] IP,
  input  logic [7:0] BrkAddr,
  input  logic       HaltReq,
  output logic       Go,
  output logic       Running,
  output logic [1:0] State,
  output logic       BrkArmed
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_BRK  = 2'b11
  } state_e;

  localparam int              DB_W     = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_MAX);

  state_e state_q, state_d;
  logic   go_raw, skip_set, brk_hit;

  // Turbo switch synchroniser
  logic turbo_q1, turbo_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      turbo_q1 <= 1'b0;
      turbo_s  <= 1'b0;
    end else begin
      turbo_q1 <= Turbo;
      turbo_s  <= turbo_q1;
    end
  end

  // Button conditioning: sync, debounce, rising-edge pulse
  logic [2:0]      btn_q1, btn_s, btn_prev, db_lvl, db_lvl_d, btn_p;
  logic [DB_W-1:0] db_cnt [3];
  logic            step_p, run_p, arm_p;

  // NOTE: the small per-button counter array is reset explicitly; it is a few flops, not a RAM.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      btn_q1   <= '0;
      btn_s    <= '0;
      btn_prev <= '0;
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      btn_q1   <= Btns;
      btn_s    <= btn_q1;
      btn_prev <= btn_s;
      db_lvl_d <= db_lvl;
      for (int i = 0; i < 3; i++) begin
        if (btn_s[i] != btn_prev[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] == DB_LAST)
          db_lvl[i] <= btn_s[i];
        else
          db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  assign btn_p  = db_lvl & ~db_lvl_d;
  assign step_p = btn_p[0];
  assign run_p  = btn_p[1];
  assign arm_p  = btn_p[2];

  // Slow-run prescaler; free-runs in every state
  logic [CNT_W-1:0] cnt;
  logic             tick, issue;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (cnt == CNT_LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick  = (cnt == '0);
  assign issue = tick || turbo_s;

`ifdef CPU_BREAKPOINT_EN
  logic       armed_q, skip_q;
  logic [7:0] ip_prev;

  // skip lets the instruction at BrkAddr execute once after leaving BRK
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      armed_q <= 1'b0;
      skip_q  <= 1'b0;
      ip_prev <= '0;
    end else begin
      ip_prev <= IP;
      if (arm_p)
        armed_q <= ~armed_q;
      if (skip_set)
        skip_q <= 1'b1;
      else if ((Go && (IP != BrkAddr)) || (IP != ip_prev))
        skip_q <= 1'b0;
    end
  end

  assign brk_hit  = armed_q && (IP == BrkAddr) && !skip_q;
  assign BrkArmed = armed_q;
`else
  logic unused_bp;
  assign unused_bp = ^{IP, BrkAddr, arm_p, skip_set};
  assign brk_hit   = 1'b0;
  assign BrkArmed  = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    go_raw   = 1'b0;
    skip_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        go_raw = issue && !brk_hit && !HaltReq;
        if (HaltReq)              state_d = ST_HALT;
        else if (brk_hit && issue) state_d = ST_BRK;
        else if (run_p)           state_d = ST_HALT;
      end
      ST_HALT: begin
        if (step_p)     state_d = ST_STEP;
        else if (run_p) state_d = ST_RUN;
      end
      ST_STEP: begin
        go_raw  = 1'b1;
        state_d = ST_HALT;
      end
      ST_BRK: begin
        if (step_p) begin
          state_d  = ST_STEP;
          skip_set = 1'b1;
        end else if (run_p) begin
          state_d  = ST_RUN;
          skip_set = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Reset masks Go asynchronously so an aborted step never issues
  assign Go      = go_raw && !Reset;
  assign Running = (state_q == ST_RUN);
  assign State   = state_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed self-checking bench for cpu_step_ctrl with TICK_MAX=9, DB_CYCLES=4.
module tb_cpu_step_ctrl;

  logic       Clock = 1'b0;
  logic       Reset, Turbo, HaltReq;
  logic [2:0] Btns;
  logic [7:0] IP, BrkAddr;
  logic       Go, Running, BrkArmed;
  logic [1:0] State;

  int n_vec = 0, n_err = 0, cyc = 0;
  int go_cnt = 0, step_cnt = 0, go_at_brk = 0;
  bit ip_follow = 1'b0;

  cpu_step_ctrl #(.TICK_MAX(9), .CNT_W(4), .DB_CYCLES(4)) dut (
    .Clock(Clock), .Reset(Reset), .Turbo(Turbo), .Btns(Btns), .IP(IP),
    .BrkAddr(BrkAddr), .HaltReq(HaltReq), .Go(Go), .Running(Running),
    .State(State), .BrkArmed(BrkArmed)
  );

  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL timeout: got no summary, expected run to finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: observe Go mid-cycle, let the CPU model follow it, return just after the edge
  task automatic cycle();
    logic g;
    @(negedge Clock);
    g = Go;
    if (g) go_cnt++;
    if (g && IP == BrkAddr) go_at_brk++;
    if (State == 2'b10) step_cnt++;
    @(posedge Clock);
    #1;
    if (ip_follow && g) IP = IP + 8'd1;
    cyc++;
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    go_cnt = 0; step_cnt = 0; go_at_brk = 0;
    Btns = mask;
    repeat (hold) cycle();
    Btns = '0;
    repeat (12) cycle();
  endtask

  task automatic wait_state(input string tag, input logic [1:0] exp, input int max);
    int n = 0;
    while (State !== exp && n < max) begin
      cycle();
      n++;
    end
    check(tag, State, exp);
  endtask

  initial begin
    Reset = 1'b1; Turbo = 1'b0; HaltReq = 1'b0; Btns = '0; IP = 8'h00; BrkAddr = 8'h05;
    @(posedge Clock); #1;
    repeat (2) cycle();
    check("rst_go", Go, 0);
    check("rst_state", State, 2'b01);
    check("rst_running", Running, 1);
    check("rst_armed", BrkArmed, 0);

    // Free run: Go on release cycle, then every 10 cycles
    Reset = 1'b0; cyc = 0; #1;
    for (int i = 0; i < 25; i++) begin
      check("free_go", Go, (cyc % 10 == 0));
      cycle();
    end
    check("free_state", State, 2'b01);

    // Turbo on at i=3 (Go every cycle from i=5), off at i=20 (tick rate from i=22)
    for (int i = 0; i < 40; i++) begin
      if (i == 3) Turbo = 1'b1;
      if (i == 20) Turbo = 1'b0;
      check("turbo_go", Go, (cyc % 10 == 0) || (i >= 5 && i < 22));
      cycle();
    end

    // Halt and single-step
    press(3'b010, 6);
    check("halt_state", State, 2'b00);
    go_cnt = 0;
    repeat (50) cycle();
    check("halt_no_go", go_cnt, 0);
    check("halt_still", State, 2'b00);

    press(3'b001, 6);
    check("step_go", go_cnt, 1);
    check("step_seen", step_cnt, 1);
    check("step_halt", State, 2'b00);

    press(3'b001, 30);
    check("step_held_go", go_cnt, 1);
    check("step_held_halt", State, 2'b00);

    press(3'b011, 6);
    check("both_step", step_cnt, 1);
    check("both_go", go_cnt, 1);
    check("both_halt", State, 2'b00);

    press(3'b010, 6);
    check("resume_run", State, 2'b01);

    // HaltReq in turbo RUN
    Turbo = 1'b1;
    repeat (4) cycle();
    check("hr_turbo_go", Go, 1);
    HaltReq = 1'b1; #1;
    check("hr_go_low", Go, 0);
    check("hr_state_run", State, 2'b01);
    cycle();
    check("hr_halt", State, 2'b00);
    HaltReq = 1'b0; #1;
    check("hr_halt_go", Go, 0);

`ifdef CPU_BREAKPOINT_EN
    press(3'b100, 6);
    check("arm", BrkArmed, 1);
    IP = 8'h03; ip_follow = 1'b1;
    press(3'b010, 6);
    check("brk_go_count", go_cnt, 2);
    check("brk_state", State, 2'b11);
    check("brk_ip", IP, 8'h05);
    check("brk_go_low", Go, 0);
    go_cnt = 0;
    repeat (5) cycle();
    check("brk_hold", go_cnt, 0);
    press(3'b010, 6);
    check("brk_once", go_at_brk, 1);
    check("brk_resume", State, 2'b01);
    check("brk_ip_moved", IP > 8'h06, 1);
    ip_follow = 1'b0;
`else
    press(3'b100, 6);
    check("arm_disabled", BrkArmed, 0);
    check("arm_disabled_state", State, 2'b00);
`endif

    // Reset during STEP
    Turbo = 1'b0; HaltReq = 1'b1;
    cycle();
    HaltReq = 1'b0;
    check("pre_step_halt", State, 2'b00);
    Btns = 3'b001;
    wait_state("step_reached", 2'b10, 20);
    Reset = 1'b1; Btns = '0; #1;
    check("rst_step_go", Go, 0);
    check("rst_step_state", State, 2'b01);
    check("rst_step_armed", BrkArmed, 0);
    repeat (2) cycle();
    Reset = 1'b0; cyc = 0; #1;
    check("rst_rel_go", Go, 1);

    // Reset mid-debounce
    Btns = 3'b010;
    repeat (4) cycle();
    Reset = 1'b1; Btns = '0; #1;
    check("rst_db_go", Go, 0);
    cycle();
    Reset = 1'b0; #1;
    go_cnt = 0;
    repeat (20) cycle();
    check("mid_db_state", State, 2'b01);
    check("mid_db_gos", go_cnt, 2);
    check("mid_db_armed", BrkArmed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
